fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
Parametrised prefetching instruction fetch unit. Issues sequential program-memory reads from an internal fetch PC and buffers up to QUEUE_DEPTH instructions, each tagged with its PC. The decoder consumes entries through a valid/ready handshake. A redirect (branch or jump) flushes the queue, drops any in-flight response and restarts fetching at the new PC. The block sits between program memory and the core decode stage.

Parameters:
PROGRAM_MEM_ADDR_BITS, 8, program memory address width; fetch PC width
PROGRAM_MEM_DATA_BITS, 16, instruction width
QUEUE_DEPTH, 4, buffered instructions; power of two, >= 2

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
enable  input  1  permits issue of new memory requests
redirect_valid  input  1  flush and restart at redirect_pc
redirect_pc  input  ADDR_BITS  new fetch PC
program_mem_read_valid  output  1  memory read request
program_mem_read_address  output  ADDR_BITS  request address
program_mem_read_ready  input  1  memory response; data valid this cycle
program_mem_read_data  input  DATA_BITS  returned instruction
instr_valid  output  1  queue head is valid
instr_ready  input  1  consumer accepts head
instruction  output  DATA_BITS  head instruction
instr_pc  output  ADDR_BITS  PC of head instruction
queue_count  output  $clog2(QUEUE_DEPTH)+1  occupied entries

Behaviour:
- Reset (reset==0, asynchronous) forces the following immediately: state=IDLE, program_mem_read_valid=0, program_mem_read_address=0, fetch_pc=0, queue empty, instr_valid=0, queue_count=0. Instruction and instr_pc storage are don't-care but read 0 after reset.
- Memory handshake:
  - A transfer completes on any cycle with valid && ready.
  - Valid and address are registered and held stable until ready. Valid never drops before ready except on reset.
  - One request in flight at most.
- count_next = count + push - pop. Push occurs on a REQUEST-state response. Pop occurs when instr_valid && instr_ready.
- States:
  - IDLE: if enable && !redirect_valid && count_next < QUEUE_DEPTH, then valid<=1, address<=fetch_pc, go to REQUEST.
  - REQUEST, ready high:
    - Push {fetch_pc, data} and increment fetch_pc (wraps modulo 2^ADDR_BITS).
    - If enable && count_next < QUEUE_DEPTH, stay in REQUEST with address<=fetch_pc+1. This gives back-to-back issue, one instruction per cycle sustained.
    - Otherwise valid<=0 and go to IDLE.
  - DISCARD: the in-flight request is kept until ready. The response is dropped, then valid<=0 and go to IDLE.
- Redirect (cycle t): queue is flushed (count=0 at t+1) and fetch_pc<=redirect_pc.
  - In REQUEST with ready low: go to DISCARD.
  - In REQUEST with ready high: data is dropped, valid<=0, go to IDLE.
  - A pop in the same cycle counts as accepted and is then flushed.
  - Redirect has priority over push.
  - First request to the new PC: valid at t+2 from IDLE, or later after DISCARD.
- enable low: no new request. An outstanding request completes normally.
- Output path:
  - instr_valid = (count != 0).
  - instruction and instr_pc come combinationally from the head storage entry.
  - When the queue is full, push is impossible because issue is gated by count_next.
- Pointers wrap modulo QUEUE_DEPTH. Push and pop in the same cycle leave count unchanged.

Optional Feature:
- Macro: FETCH_QUEUE_PERF_EN.
- When defined, two ports are added:
  - perf_fetch_count (output, 32): accepted responses pushed into the queue.
  - perf_stall_cycles (output, 32): cycles with program_mem_read_valid && !program_mem_read_ready.
- Both counters are reset to 0, saturate at 2^32-1, and are not cleared by redirect.
- When not defined, these ports and their logic are absent.

Decomposition:
- Package fetch_pkg holds the fetch_state_t enum {IDLE, REQUEST, DISCARD}.
- Sub-module fetch_fifo: parametrised WIDTH/DEPTH storage with push, pop, flush and count. It is instantiated once with WIDTH = ADDR_BITS + DATA_BITS.

Test Plan:
1. Redirect to 0x10, memory ready 1 cycle after valid, instr_ready=0 -> requests 0x10..0x13 complete; valid then stays 0; queue_count=4; instr_pc=0x10.
2. Memory ready tied high, instr_ready=1 -> after startup, instr_valid continuously 1 with instr_pc incrementing by 1 per cycle.
3. Request to 0x12 outstanding with ready low, redirect to 0x80, ready held low 3 more cycles -> valid held at address 0x12; response dropped; queue_count=0; next request addresses 0x80.
4. Redirect to 0xFE with 8-bit addresses -> requests 0xFE, 0xFF, 0x00, 0x01; instr_pc sequence matches.
5. reset driven low mid-REQUEST -> program_mem_read_valid=0 and queue_count=0 without a clock edge. After release, first request is to 0x00.
6. With FETCH_QUEUE_PERF_EN defined, ready withheld for 3 cycles on one request -> perf_stall_cycles=3, perf_fetch_count increments by 1.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the prefetching instruction fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        DISCARD
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer with push, pop, flush and occupancy count; head entry read combinationally.
module fetch_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [PtrW:0]    count_q;
    logic [PtrW:0]    count_d;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    // Flush wins over push/pop; a pop in the flush cycle is simply absorbed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wdata;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Prefetching instruction fetch unit: sequential program-memory reads into a PC-tagged queue.
// Optional performance counters are built when FETCH_QUEUE_PERF_EN is defined.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned PROGRAM_MEM_ADDR_BITS = 8,
    parameter int unsigned PROGRAM_MEM_DATA_BITS = 16,
    parameter int unsigned QUEUE_DEPTH           = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enable,
    input  logic                             redirect_valid,
    input  logic [PROGRAM_MEM_ADDR_BITS-1:0] redirect_pc,
    output logic                             program_mem_read_valid,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] program_mem_read_address,
    input  logic                             program_mem_read_ready,
    input  logic [PROGRAM_MEM_DATA_BITS-1:0] program_mem_read_data,
    output logic                             instr_valid,
    input  logic                             instr_ready,
    output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0] instr_pc,
    output logic [$clog2(QUEUE_DEPTH):0]     queue_count
`ifdef FETCH_QUEUE_PERF_EN
    ,
    output logic [31:0]                      perf_fetch_count,
    output logic [31:0]                      perf_stall_cycles
`endif
);

    localparam int unsigned CountW = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned EntryW = PROGRAM_MEM_ADDR_BITS + PROGRAM_MEM_DATA_BITS;
    localparam logic [CountW-1:0] DepthCnt = CountW'(QUEUE_DEPTH);

    fetch_state_t                     state_q;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] fetch_pc_q;
    logic                             mem_valid_q;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] mem_addr_q;

    logic              push;
    logic              pop;
    logic [CountW-1:0] count;
    logic [CountW-1:0] count_next;
    logic              has_room;
    logic [EntryW-1:0] head;

    assign push        = (state_q == REQUEST) && program_mem_read_ready && !redirect_valid;
    assign instr_valid = (count != '0);
    assign pop         = instr_valid && instr_ready;
    assign count_next  = count + CountW'(push) - CountW'(pop);
    assign has_room    = (count_next < DepthCnt);

    fetch_fifo #(
        .WIDTH (EntryW),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect_valid),
        .wdata ({fetch_pc_q, program_mem_read_data}),
        .rdata (head),
        .count (count)
    );

    // In REQUEST, fetch_pc_q is the address of the request in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            fetch_pc_q  <= '0;
            mem_valid_q <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_pc;
                    end else if (enable && has_room) begin
                        mem_valid_q <= 1'b1;
                        mem_addr_q  <= fetch_pc_q;
                        state_q     <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_pc;
                        if (program_mem_read_ready) begin
                            mem_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end else begin
                            state_q <= DISCARD;
                        end
                    end else if (program_mem_read_ready) begin
                        fetch_pc_q <= fetch_pc_q + 1'b1;
                        if (enable && has_room) begin
                            mem_addr_q <= fetch_pc_q + 1'b1;
                        end else begin
                            mem_valid_q <= 1'b0;
                            state_q     <= IDLE;
                        end
                    end
                end
                DISCARD: begin
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_pc;
                    end
                    if (program_mem_read_ready) begin
                        mem_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    mem_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign program_mem_read_valid   = mem_valid_q;
    assign program_mem_read_address = mem_addr_q;
    assign instr_pc                 = head[EntryW-1 -: PROGRAM_MEM_ADDR_BITS];
    assign instruction              = head[PROGRAM_MEM_DATA_BITS-1:0];
    assign queue_count              = count;

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;

    // Saturating counters that survive redirects.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (push && (perf_fetch_q != '1)) begin
                perf_fetch_q <= perf_fetch_q + 1'b1;
            end
            if (mem_valid_q && !program_mem_read_ready && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 1'b1;
            end
        end
    end

    assign perf_fetch_count  = perf_fetch_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with a latency-programmable memory model.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [7:0]  redirect_pc = '0;
    logic        pm_valid;
    logic [7:0]  pm_addr;
    logic        mem_ready = 1'b0;
    logic [15:0] mem_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [15:0] instruction;
    logic [7:0]  instr_pc;
    logic [2:0]  queue_count;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] perf_fetch_count;
    logic [31:0] perf_stall_cycles;
`endif

    int vectors = 0;
    int miscompares = 0;
    int mem_lat = 0;
    bit mem_hold = 1'b0;
    int wait_cnt = 0;

    fetch_queue #(
        .PROGRAM_MEM_ADDR_BITS (8),
        .PROGRAM_MEM_DATA_BITS (16),
        .QUEUE_DEPTH           (4)
    ) dut (
        .clk                      (clk),
        .reset                    (reset),
        .enable                   (enable),
        .redirect_valid           (redirect_valid),
        .redirect_pc              (redirect_pc),
        .program_mem_read_valid   (pm_valid),
        .program_mem_read_address (pm_addr),
        .program_mem_read_ready   (mem_ready),
        .program_mem_read_data    (mem_data),
        .instr_valid              (instr_valid),
        .instr_ready              (instr_ready),
        .instruction              (instruction),
        .instr_pc                 (instr_pc),
        .queue_count              (queue_count)
`ifdef FETCH_QUEUE_PERF_EN
        ,
        .perf_fetch_count         (perf_fetch_count),
        .perf_stall_cycles        (perf_stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return {a ^ 8'h5A, a};
    endfunction

    // Memory: each request sees mem_lat ready-low cycles before its response.
    initial forever begin
        @(posedge clk);
        #1;
        if (!pm_valid) begin
            mem_ready = 1'b0;
            wait_cnt  = 0;
        end else begin
            if (mem_ready) wait_cnt = 0;
            if (!mem_hold && wait_cnt >= mem_lat) begin
                mem_ready = 1'b1;
                mem_data  = mem_word(pm_addr);
            end else begin
                mem_ready = 1'b0;
                if (!mem_hold) wait_cnt++;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic redirect_to(input logic [7:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        @(negedge clk);
        redirect_valid = 1'b0;
    endtask

    task automatic wait_count(input string tag, input int target);
        for (int i = 0; i < 40 && queue_count != 3'(target); i++) @(negedge clk);
        check_eq(tag, 32'(queue_count), 32'(target));
    endtask

    task automatic wait_req(input string tag, input logic [7:0] addr);
        for (int i = 0; i < 40 && !pm_valid; i++) @(negedge clk);
        check_eq({tag, "_valid"}, 32'(pm_valid), 32'd1);
        check_eq({tag, "_addr"}, 32'(pm_addr), 32'(addr));
    endtask

    task automatic pop_check(input string tag, input logic [7:0] pc);
        check_eq({tag, "_pc"}, 32'(instr_pc), 32'(pc));
        check_eq({tag, "_ins"}, 32'(instruction), 32'(mem_word(pc)));
        instr_ready = 1'b1;
        @(negedge clk);
        instr_ready = 1'b0;
    endtask

    task automatic drain();
        enable      = 1'b0;
        instr_ready = 1'b0;
        mem_hold    = 1'b0;
        for (int i = 0; i < 40 && pm_valid; i++) @(negedge clk);
        instr_ready = 1'b1;
        for (int i = 0; i < 40 && queue_count != 3'd0; i++) @(negedge clk);
        instr_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
`ifdef FETCH_QUEUE_PERF_EN
        logic [31:0] fetch0;
        logic [31:0] stall0;
`endif
        #12;
        check_eq("rst_valid", 32'(pm_valid), 32'd0);
        check_eq("rst_addr", 32'(pm_addr), 32'd0);
        check_eq("rst_count", 32'(queue_count), 32'd0);
        check_eq("rst_ivalid", 32'(instr_valid), 32'd0);
        check_eq("rst_ins", 32'(instruction), 32'd0);
        check_eq("rst_ipc", 32'(instr_pc), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // 1: fill from 0x10 with one-cycle memory latency, consumer stalled
        mem_lat = 1;
        enable  = 1'b1;
        redirect_to(8'h10);
        wait_count("t1_count", 4);
        check_eq("t1_valid_off", 32'(pm_valid), 32'd0);
        repeat (3) @(negedge clk);
        check_eq("t1_count_hold", 32'(queue_count), 32'd4);
        check_eq("t1_valid_hold", 32'(pm_valid), 32'd0);
        enable = 1'b0;
        pop_check("t1_e0", 8'h10);
        pop_check("t1_e1", 8'h11);
        pop_check("t1_e2", 8'h12);
        pop_check("t1_e3", 8'h13);
        check_eq("t1_empty", 32'(instr_valid), 32'd0);

        // 2: memory always ready, consumer always ready -> one instruction per cycle
        drain();
        mem_lat     = 0;
        instr_ready = 1'b1;
        enable      = 1'b1;
        redirect_to(8'h20);
        for (int i = 0; i < 40 && !instr_valid; i++) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            check_eq("t2_ivalid", 32'(instr_valid), 32'd1);
            check_eq("t2_pc", 32'(instr_pc), 32'h20 + 32'(i));
            @(negedge clk);
        end

        // 3: redirect while a request is stalled -> response discarded
        drain();
        mem_hold = 1'b1;
        enable   = 1'b1;
        redirect_to(8'h12);
        wait_req("t3_req", 8'h12);
        redirect_to(8'h80);
        check_eq("t3_count", 32'(queue_count), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check_eq("t3_hold_valid", 32'(pm_valid), 32'd1);
            check_eq("t3_hold_addr", 32'(pm_addr), 32'h12);
            @(negedge clk);
        end
        mem_hold = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("t3_dropped_valid", 32'(pm_valid), 32'd0);
        check_eq("t3_dropped_count", 32'(queue_count), 32'd0);
        @(negedge clk);
        check_eq("t3_new_valid", 32'(pm_valid), 32'd1);
        check_eq("t3_new_addr", 32'(pm_addr), 32'h80);
        wait_count("t3_first", 1);
        check_eq("t3_first_pc", 32'(instr_pc), 32'h80);

        // 4: address wrap at the top of program memory
        drain();
        enable = 1'b1;
        redirect_to(8'hFE);
        wait_count("t4_count", 4);
        enable = 1'b0;
        pop_check("t4_e0", 8'hFE);
        pop_check("t4_e1", 8'hFF);
        pop_check("t4_e2", 8'h00);
        pop_check("t4_e3", 8'h01);
        check_eq("t4_empty", 32'(queue_count), 32'd0);

        // 5: asynchronous reset in the middle of a stalled request
        drain();
        enable = 1'b1;
        redirect_to(8'h40);
        wait_count("t5_fill", 2);
        mem_hold = 1'b1;
        @(negedge clk);
        check_eq("t5_pre_count", 32'(queue_count), 32'd3);
        check_eq("t5_pre_addr", 32'(pm_addr), 32'h43);
        #2;
        reset = 1'b0;
        #1;
        check_eq("t5_rst_valid", 32'(pm_valid), 32'd0);
        check_eq("t5_rst_count", 32'(queue_count), 32'd0);
        check_eq("t5_rst_ivalid", 32'(instr_valid), 32'd0);
        @(negedge clk);
        reset    = 1'b1;
        mem_hold = 1'b0;
        @(negedge clk);
        check_eq("t5_restart_valid", 32'(pm_valid), 32'd1);
        check_eq("t5_restart_addr", 32'(pm_addr), 32'h00);
        wait_count("t5_first", 1);
        check_eq("t5_first_pc", 32'(instr_pc), 32'h00);

`ifdef FETCH_QUEUE_PERF_EN
        // 6: one request with three stall cycles
        drain();
        fetch0  = perf_fetch_count;
        stall0  = perf_stall_cycles;
        mem_lat = 3;
        enable  = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        check_eq("t6_req", 32'(pm_valid), 32'd1);
        for (int i = 0; i < 20 && pm_valid; i++) @(negedge clk);
        check_eq("t6_stall", perf_stall_cycles - stall0, 32'd3);
        check_eq("t6_fetch", perf_fetch_count - fetch0, 32'd1);
`endif

        drain();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
